// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: PC owner and ROM fetch front end feeding decode through a small {pc, inst} FIFO.
// Optional misaligned-fetch marking and halt enabled by defining FETCH_ADEL_CHECK_EN.
module inst_fetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target_addr,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
`ifdef FETCH_ADEL_CHECK_EN
  output logic        id_adel,
`endif
  output logic [31:0] id_inst
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] r_pcs [DEPTH];
  logic [31:0] r_insts [DEPTH];
  logic [31:0] r_pc;
  logic        r_ce;
  logic [AW:0] r_cnt;
  logic [AW-1:0] r_rd, r_wr;
  logic        w_redirect, w_pop, w_push, w_full, w_halt, w_mis;
  logic [31:0] w_inst;
`ifdef FETCH_ADEL_CHECK_EN
  logic r_halt;
  logic r_adels [DEPTH];
  assign w_halt = r_halt;
  assign w_mis = r_pc[1:0] != 2'b00;
  assign id_adel = id_valid && r_adels[r_rd];
  always_ff @(posedge clk)
    if (rst || w_redirect) r_halt <= 1'b0;
    else if (w_push && w_mis) r_halt <= 1'b1;
  always_ff @(posedge clk)
    if (w_push) r_adels[r_wr] <= w_mis;
`else
  assign w_halt = 1'b0;
  assign w_mis = 1'b0;
`endif
  assign rom_ce = r_ce;
  assign rom_addr = r_pc;
  assign w_redirect = flush || branch_flag;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign id_valid = r_cnt != '0;
  assign w_pop = id_valid && id_ready;
  assign w_push = r_ce && !w_redirect && !w_halt && (!w_full || w_pop);
  // A misaligned fetch is replaced by a zero word carrying the adel flag.
  assign w_inst = w_mis ? 32'h0 : rom_inst;
  assign id_pc = id_valid ? r_pcs[r_rd] : 32'h0;
  assign id_inst = id_valid ? r_insts[r_rd] : 32'h0;
  always_ff @(posedge clk)
    if (w_push) begin
      r_pcs[r_wr] <= r_pc;
      r_insts[r_wr] <= w_inst;
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_pc <= RESET_PC;
      r_ce <= 1'b0;
      r_cnt <= '0;
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      r_ce <= 1'b1;
      if (w_redirect) begin
        r_pc <= flush ? new_pc : branch_target_addr;
        r_cnt <= '0;
        r_rd <= '0;
        r_wr <= '0;
      end else begin
        if (w_push) begin
          r_pc <= r_pc + 32'd4;
          r_wr <= r_wr + 1'b1;
        end
        if (w_pop) r_rd <= r_rd + 1'b1;
        if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
        else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb_inst_fetch_buf: directed checks of fetch, backpressure, redirects and PC wrap.
module tb_inst_fetch_buf;
  logic        clk = 1'b0;
  logic        rst, flush, branch_flag, id_ready;
  logic [31:0] new_pc, branch_target_addr;
  logic        rom_ce, id_valid;
  logic [31:0] rom_addr, rom_inst, id_pc, id_inst;
  int total = 0;
  int bad = 0;
`ifdef FETCH_ADEL_CHECK_EN
  logic id_adel;
`endif
  always #5 clk = ~clk;
  // ROM word at byte address a is 32'h1000_0000 + a/4 (low address bits ignored).
  assign rom_inst = 32'h1000_0000 + (rom_addr >> 2);
  inst_fetch_buf dut (
    .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target_addr(branch_target_addr),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
`ifdef FETCH_ADEL_CHECK_EN
    .id_adel(id_adel),
`endif
    .id_inst(id_inst)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
    chk({tag, "_pc"}, id_pc, pc);
    chk({tag, "_inst"}, id_inst, 32'h1000_0000 + (pc >> 2));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; branch_flag = 1'b0; id_ready = 1'b0;
    new_pc = '0; branch_target_addr = '0;
    step();
    chk("rst_ce", {31'b0, rom_ce}, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_addr", rom_addr, 32'h0);
    rst = 1'b0; id_ready = 1'b1;
    step();
    chk("ce_up", {31'b0, rom_ce}, 32'd1);
    chk("ce_up_valid", {31'b0, id_valid}, 32'd0);
    step();
    head("run0", 32'h0);
    for (int i = 1; i < 6; i++) begin
      step();
      head("run", 32'(4 * i));
    end
    // backpressure from a fresh start
    id_ready = 1'b0;
    do_reset();
    chk("rst2_valid", {31'b0, id_valid}, 32'd0);
    chk("rst2_addr", rom_addr, 32'h0);
    step();
    for (int i = 0; i < 8; i++) step();
    chk("full_addr", rom_addr, 32'h10);
    head("full_head", 32'h0);
    id_ready = 1'b1;
    for (int i = 1; i < 7; i++) begin
      step();
      head("drain", 32'(4 * i));
    end
    // branch with three entries buffered
    id_ready = 1'b0;
    do_reset();
    step();
    for (int i = 0; i < 3; i++) step();
    chk("pre_br_addr", rom_addr, 32'hC);
    branch_flag = 1'b1; branch_target_addr = 32'h40;
    step();
    branch_flag = 1'b0;
    chk("br_valid", {31'b0, id_valid}, 32'd0);
    chk("br_addr", rom_addr, 32'h40);
    step();
    head("br_first", 32'h40);
    id_ready = 1'b1;
    step();
    head("br_second", 32'h44);
    // flush wins over branch
    flush = 1'b1; new_pc = 32'h20; branch_flag = 1'b1; branch_target_addr = 32'h80;
    step();
    flush = 1'b0; branch_flag = 1'b0;
    chk("fl_valid", {31'b0, id_valid}, 32'd0);
    chk("fl_addr", rom_addr, 32'h20);
    step();
    head("fl_first", 32'h20);
    step();
    head("fl_second", 32'h24);
    // pc wrap
    flush = 1'b1; new_pc = 32'hFFFF_FFF8;
    step();
    flush = 1'b0;
    chk("wr_valid", {31'b0, id_valid}, 32'd0);
    step();
    head("wrap0", 32'hFFFF_FFF8);
    step();
    head("wrap1", 32'hFFFF_FFFC);
    step();
    head("wrap2", 32'h0);
    // reset beats a simultaneous flush
    rst = 1'b1; flush = 1'b1; new_pc = 32'h80;
    step();
    rst = 1'b0; flush = 1'b0;
    chk("rstfl_addr", rom_addr, 32'h0);
    chk("rstfl_ce", {31'b0, rom_ce}, 32'd0);
    chk("rstfl_valid", {31'b0, id_valid}, 32'd0);
    // redirect while rom_ce is still low
    branch_flag = 1'b1; branch_target_addr = 32'h40;
    step();
    branch_flag = 1'b0;
    chk("brce_addr", rom_addr, 32'h40);
    chk("brce_ce", {31'b0, rom_ce}, 32'd1);
    step();
    head("brce_first", 32'h40);
`ifdef FETCH_ADEL_CHECK_EN
    branch_flag = 1'b1; branch_target_addr = 32'h42;
    step();
    branch_flag = 1'b0;
    step();
    chk("adel_valid", {31'b0, id_valid}, 32'd1);
    chk("adel_pc", id_pc, 32'h42);
    chk("adel_inst", id_inst, 32'h0);
    chk("adel_flag", {31'b0, id_adel}, 32'd1);
    step();
    chk("adel_halt1", {31'b0, id_valid}, 32'd0);
    step();
    chk("adel_halt2", {31'b0, id_valid}, 32'd0);
    flush = 1'b1; new_pc = 32'h0;
    step();
    flush = 1'b0;
    step();
    head("adel_resume", 32'h0);
    chk("adel_clear", {31'b0, id_adel}, 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
